// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory_access load/store unit: funct3 encodings, FSM states
// and the store lane / alignment helpers.
package memory_access_pkg;

    typedef enum logic [2:0] {
        MEM_LB  = 3'b000,
        MEM_LH  = 3'b001,
        MEM_LW  = 3'b010,
        MEM_LBU = 3'b100,
        MEM_LHU = 3'b101
    } mem_control_t;

    // Stores reuse the LB/LH/LW funct3 encodings; the R/W enables disambiguate.
    localparam mem_control_t MEM_SB = MEM_LB;
    localparam mem_control_t MEM_SH = MEM_LH;
    localparam mem_control_t MEM_SW = MEM_LW;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t MEM_IDLE = 2'd0;
    localparam mem_state_t MEM_REQ  = 2'd1;
    localparam mem_state_t MEM_DONE = 2'd2;

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            MEM_SB:  return 4'b0001 << addr_lo;
            MEM_SH:  return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3)
            MEM_SB:  return {4{data[7:0]}};
            MEM_SH:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_load_extender.sv
// Combinational load formatter: picks the byte/half lane from the read word and
// sign- or zero-extends it according to funct3.
module memory_access_load_extender
    import memory_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            MEM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data_o = {24'h0, byte_sel};
            MEM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// RV32I memory-stage load/store unit driving a req/ready data bus. Optional misaligned-access
// trapping is enabled by defining MISALIGN_TRAP_EN (adds the Misaligned_M output).
module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MEM_R_En_M,
    input  logic        MEM_W_En_M,
    input  logic [2:0]  MEM_Control_M,
    input  logic [31:0] ALU_Result_M,
    input  logic [31:0] W_Data_M,
    output logic        DMEM_Req,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_Addr,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WData,
    input  logic        DMEM_Ready,
    input  logic [31:0] DMEM_RData,
    output logic [31:0] Load_Data_M,
    output logic        MEM_Done_M,
    output logic        Stall_M,
`ifdef MISALIGN_TRAP_EN
    output logic        Misaligned_M,
`endif
    output logic        Bus_Error_M
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       load_q, load_d;
    logic              err_q, err_d;
`ifdef MISALIGN_TRAP_EN
    logic              mis_q, mis_d;
`endif
    logic [31:0]       load_fmt;
    logic              op_valid;

    assign op_valid = MEM_R_En_M | MEM_W_En_M;

    memory_access_load_extender u_load_extender (
        .rdata_i   (DMEM_RData),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .data_o    (load_fmt)
    );

    always_comb begin
        // NOTE: every _d gets a default before the case so no path infers a latch.
        state_d = state_q;
        cnt_d   = '0;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        err_d   = err_q;
`ifdef MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            MEM_IDLE: begin
                if (op_valid) begin
                    we_d    = MEM_W_En_M;
                    f3_d    = MEM_Control_M;
                    addr_d  = ALU_Result_M;
                    be_d    = MEM_W_En_M ? store_be(MEM_Control_M, ALU_Result_M[1:0]) : 4'b1111;
                    wdata_d = MEM_W_En_M ? store_wdata(MEM_Control_M, W_Data_M) : 32'h0;
                    load_d  = 32'h0;
                    err_d   = 1'b0;
                    state_d = MEM_REQ;
`ifdef MISALIGN_TRAP_EN
                    mis_d   = is_misaligned(MEM_Control_M, ALU_Result_M[1:0]);
                    if (mis_d) begin
                        state_d = MEM_DONE;
                    end
`endif
                end
            end
            MEM_REQ: begin
                // Ready on the final counted cycle still wins over the timeout.
                if (DMEM_Ready) begin
                    load_d  = we_q ? 32'h0 : load_fmt;
                    state_d = MEM_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    load_d  = 32'h0;
                    err_d   = 1'b1;
                    state_d = MEM_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!RST_N) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'b0;
            wdata_q <= 32'h0;
            load_q  <= 32'h0;
            err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            err_q   <= err_d;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign DMEM_Req    = (state_q == MEM_REQ);
    assign DMEM_WE     = DMEM_Req & we_q;
    assign DMEM_Addr   = {addr_q[31:2], 2'b00};
    assign DMEM_BE     = be_q;
    assign DMEM_WData  = wdata_q;
    assign MEM_Done_M  = (state_q == MEM_DONE);
    assign Load_Data_M = load_q;
    assign Bus_Error_M = MEM_Done_M & err_q;
    assign Stall_M     = DMEM_Req | ((state_q == MEM_IDLE) & op_valid);
`ifdef MISALIGN_TRAP_EN
    assign Misaligned_M = MEM_Done_M & mis_q;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: the driver queues expected bus requests and
// completions, a responder/monitor pair checks them as the DUT presents them.
module tb_memory_access;

    localparam int TO = 8;
    localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100, F_LHU = 3'b101;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MEM_R_En_M, MEM_W_En_M;
    logic [2:0]  MEM_Control_M;
    logic [31:0] ALU_Result_M, W_Data_M;
    logic        DMEM_Req, DMEM_WE, DMEM_Ready;
    logic [31:0] DMEM_Addr, DMEM_WData, DMEM_RData, Load_Data_M;
    logic [3:0]  DMEM_BE;
    logic        MEM_Done_M, Stall_M, Bus_Error_M;
`ifdef MISALIGN_TRAP_EN
    logic        Misaligned_M;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        string       name;
    } bus_exp_t;

    typedef struct {
        logic [31:0] load;
        logic        err;
        logic        mis;
        string       name;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    int        checks = 0;
    int        failures = 0;
    int        ready_delay = 0;
    logic [31:0] resp_data = 32'h0;

    always #5 CLK = ~CLK;

    memory_access #(.TIMEOUT(TO)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .MEM_R_En_M    (MEM_R_En_M),
        .MEM_W_En_M    (MEM_W_En_M),
        .MEM_Control_M (MEM_Control_M),
        .ALU_Result_M  (ALU_Result_M),
        .W_Data_M      (W_Data_M),
        .DMEM_Req      (DMEM_Req),
        .DMEM_WE       (DMEM_WE),
        .DMEM_Addr     (DMEM_Addr),
        .DMEM_BE       (DMEM_BE),
        .DMEM_WData    (DMEM_WData),
        .DMEM_Ready    (DMEM_Ready),
        .DMEM_RData    (DMEM_RData),
        .Load_Data_M   (Load_Data_M),
        .MEM_Done_M    (MEM_Done_M),
        .Stall_M       (Stall_M),
`ifdef MISALIGN_TRAP_EN
        .Misaligned_M  (Misaligned_M),
`endif
        .Bus_Error_M   (Bus_Error_M)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder and bus-request monitor.
    initial begin
        int req_cycles;
        bus_exp_t b;
        req_cycles = 0;
        DMEM_Ready = 1'b0;
        DMEM_RData = 32'h0;
        forever begin
            @(negedge CLK);
            if (DMEM_Req) begin
                if (req_cycles == 0) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_req", {31'h0, DMEM_Req}, 32'h0);
                    end else begin
                        b = bus_q.pop_front();
                        check({b.name, "_we"}, {31'h0, DMEM_WE}, {31'h0, b.we});
                        check({b.name, "_addr"}, DMEM_Addr, b.addr);
                        check({b.name, "_be"}, {28'h0, DMEM_BE}, {28'h0, b.be});
                        if (b.we) check({b.name, "_wdata"}, DMEM_WData, b.wdata);
                        check({b.name, "_stall"}, {31'h0, Stall_M}, 32'h1);
                    end
                end
                DMEM_Ready = (req_cycles == ready_delay);
                DMEM_RData = DMEM_Ready ? resp_data : 32'hBAD0_BAD0;
                req_cycles++;
            end else begin
                DMEM_Ready = 1'b0;
                DMEM_RData = 32'h0;
                req_cycles = 0;
            end
        end
    end

    // Completion monitor.
    initial begin
        done_exp_t e;
        forever begin
            @(negedge CLK);
            if (MEM_Done_M) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", {31'h0, MEM_Done_M}, 32'h0);
                end else begin
                    e = done_q.pop_front();
                    check({e.name, "_load"}, Load_Data_M, e.load);
                    check({e.name, "_err"}, {31'h0, Bus_Error_M}, {31'h0, e.err});
                    check({e.name, "_done_stall"}, {31'h0, Stall_M}, 32'h0);
                    check({e.name, "_done_req"}, {31'h0, DMEM_Req}, 32'h0);
`ifdef MISALIGN_TRAP_EN
                    check({e.name, "_mis"}, {31'h0, Misaligned_M}, {31'h0, e.mis});
`endif
                end
            end
        end
    end

    // Apply one op at the current negedge, hold it until Done, then release for one idle cycle.
    task automatic run_op(input string name, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                          input int delay, input logic bus_exp, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_ld, input logic exp_err, input logic exp_mis,
                          input int exp_lat);
        int cyc;
        if (bus_exp) bus_q.push_back('{w, exp_addr, exp_be, exp_wd, name});
        done_q.push_back('{exp_ld, exp_err, exp_mis, name});
        ready_delay   = delay;
        resp_data     = rd;
        MEM_R_En_M    = ~w;
        MEM_W_En_M    = w;
        MEM_Control_M = f3;
        ALU_Result_M  = a;
        W_Data_M      = d;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!MEM_Done_M && cyc < 60);
        check({name, "_latency"}, cyc, exp_lat);
        if (!MEM_Done_M) begin
            done_q.delete();
            bus_q.delete();
        end
        MEM_R_En_M = 1'b0;
        MEM_W_En_M = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        RST_N         = 1'b0;
        MEM_R_En_M    = 1'b0;
        MEM_W_En_M    = 1'b0;
        MEM_Control_M = 3'b0;
        ALU_Result_M  = 32'h0;
        W_Data_M      = 32'h0;
        repeat (3) @(negedge CLK);
        check("rst_req", {31'h0, DMEM_Req}, 32'h0);
        check("rst_stall", {31'h0, Stall_M}, 32'h0);
        check("rst_done", {31'h0, MEM_Done_M}, 32'h0);
        check("rst_err", {31'h0, Bus_Error_M}, 32'h0);
        check("rst_load", Load_Data_M, 32'h0);
        check("rst_addr", DMEM_Addr, 32'h0);
        check("rst_be", {28'h0, DMEM_BE}, 32'h0);
        check("rst_we", {31'h0, DMEM_WE}, 32'h0);
        RST_N = 1'b1;
        @(negedge CLK);

        //      name      w   f3     addr          wdata         rdata         dly bus addr        be       wdata         load          err mis lat
        run_op("sw",      1, F_LW,  32'h100, 32'hDEADBEEF, 32'h0,        0,  1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,        0,  0,  2);
        run_op("sb",      1, F_LB,  32'h103, 32'h123456A5, 32'h0,        0,  1, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0,        0,  0,  2);
        run_op("sh",      1, F_LH,  32'h102, 32'h00001234, 32'h0,        0,  1, 32'h100, 4'b1100, 32'h12341234, 32'h0,        0,  0,  2);
        run_op("sb0",     1, F_LB,  32'h104, 32'h0000005A, 32'h0,        1,  1, 32'h104, 4'b0001, 32'h5A5A5A5A, 32'h0,        0,  0,  3);
        run_op("sh0",     1, F_LH,  32'h108, 32'hFFFF8001, 32'h0,        0,  1, 32'h108, 4'b0011, 32'h80018001, 32'h0,        0,  0,  2);
        run_op("lb",      0, F_LB,  32'h101, 32'h0,        32'h00008000, 0,  1, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80, 0,  0,  2);
        run_op("lbu",     0, F_LBU, 32'h101, 32'h0,        32'h00008000, 0,  1, 32'h100, 4'b1111, 32'h0,        32'h00000080, 0,  0,  2);
        run_op("lhu",     0, F_LHU, 32'h102, 32'h0,        32'hBEEF0000, 0,  1, 32'h100, 4'b1111, 32'h0,        32'h0000BEEF, 0,  0,  2);
        run_op("lh",      0, F_LH,  32'h102, 32'h0,        32'hBEEF0000, 0,  1, 32'h100, 4'b1111, 32'h0,        32'hFFFFBEEF, 0,  0,  2);
        run_op("lb_pos",  0, F_LB,  32'h100, 32'h0,        32'hFFFFFF7F, 0,  1, 32'h100, 4'b1111, 32'h0,        32'h0000007F, 0,  0,  2);
        run_op("lw_slow", 0, F_LW,  32'h104, 32'h0,        32'h89ABCDEF, 3,  1, 32'h104, 4'b1111, 32'h0,        32'h89ABCDEF, 0,  0,  5);
        run_op("timeout", 0, F_LW,  32'h200, 32'h0,        32'h55555555, 999,1, 32'h200, 4'b1111, 32'h0,        32'h0,        1,  0,  TO + 2);
        run_op("rdy_last",0, F_LW,  32'h204, 32'h0,        32'h11223344, TO, 1, 32'h204, 4'b1111, 32'h0,        32'h11223344, 0,  0,  TO + 2);
`ifdef MISALIGN_TRAP_EN
        run_op("lw_mis",  0, F_LW,  32'h102, 32'h0,        32'hA1B2C3D4, 0,  0, 32'h0,   4'b0000, 32'h0,        32'h0,        0,  1,  1);
        run_op("sh_mis",  1, F_LH,  32'h101, 32'h00001234, 32'h0,        0,  0, 32'h0,   4'b0000, 32'h0,        32'h0,        0,  1,  1);
`else
        run_op("lw_trunc",0, F_LW,  32'h102, 32'h0,        32'hA1B2C3D4, 0,  1, 32'h100, 4'b1111, 32'h0,        32'hA1B2C3D4, 0,  0,  2);
`endif

        // Reset in the middle of an outstanding request.
        bus_q.push_back('{1'b0, 32'h400, 4'b1111, 32'h0, "rst_mid"});
        ready_delay   = 999;
        MEM_R_En_M    = 1'b1;
        MEM_Control_M = F_LW;
        ALU_Result_M  = 32'h400;
        repeat (3) @(negedge CLK);
        check("rst_mid_req_before", {31'h0, DMEM_Req}, 32'h1);
        RST_N      = 1'b0;
        MEM_R_En_M = 1'b0;
        @(negedge CLK);
        check("rst_mid_req", {31'h0, DMEM_Req}, 32'h0);
        check("rst_mid_stall", {31'h0, Stall_M}, 32'h0);
        check("rst_mid_done", {31'h0, MEM_Done_M}, 32'h0);
        RST_N = 1'b1;
        @(negedge CLK);

        run_op("sw_after",1, F_LW,  32'h300, 32'h0BADF00D, 32'h0,        0,  1, 32'h300, 4'b1111, 32'h0BADF00D, 32'h0,        0,  0,  2);

        repeat (3) @(negedge CLK);
        check("bus_q_empty", bus_q.size(), 32'h0);
        check("done_q_empty", done_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
